mem_controller: RTL and testbench

//  Downstream of the per-lane LSUs: arbitrates NUM_LANES lane read/write requests onto one

---
 rtl/mem_controller_if.sv | 38 +++
 rtl/mem_controller.sv | 155 +++++++++++++++
 tb/tb_mem_controller.sv | 378 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_controller_if.sv
// Lane-side and memory-side signal bundle for mem_controller.
// The slave modport is the controller's view; the master modport is the LSU/memory side.
interface mem_controller_if #(
  parameter int unsigned NUM_LANES  = 4,
  parameter int unsigned ADDR_WIDTH = 7,
  parameter int unsigned DATA_WIDTH = 64
);
  logic [NUM_LANES-1:0]            lane_read_valid;
  logic [NUM_LANES*ADDR_WIDTH-1:0] lane_read_addr;
  logic [NUM_LANES-1:0]            lane_read_ack;
  logic [NUM_LANES*DATA_WIDTH-1:0] lane_read_data;
  logic [NUM_LANES-1:0]            lane_write_valid;
  logic [NUM_LANES*ADDR_WIDTH-1:0] lane_write_addr;
  logic [NUM_LANES*DATA_WIDTH-1:0] lane_write_data;
  logic [NUM_LANES-1:0]            lane_write_ack;
  logic                            mem_read_valid;
  logic [ADDR_WIDTH-1:0]           mem_read_addr;
  logic                            mem_read_ready;
  logic [DATA_WIDTH-1:0]           mem_read_data;
  logic                            mem_write_valid;
  logic [ADDR_WIDTH-1:0]           mem_write_addr;
  logic [DATA_WIDTH-1:0]           mem_write_data;
  logic                            mem_write_ready;

  modport slave (
    input  lane_read_valid, lane_read_addr, lane_write_valid, lane_write_addr, lane_write_data,
    input  mem_read_ready, mem_read_data, mem_write_ready,
    output lane_read_ack, lane_read_data, lane_write_ack,
    output mem_read_valid, mem_read_addr, mem_write_valid, mem_write_addr, mem_write_data
  );

  modport master (
    output lane_read_valid, lane_read_addr, lane_write_valid, lane_write_addr, lane_write_data,
    output mem_read_ready, mem_read_data, mem_write_ready,
    input  lane_read_ack, lane_read_data, lane_write_ack,
    input  mem_read_valid, mem_read_addr, mem_write_valid, mem_write_addr, mem_write_data
  );
endinterface

// File: rtl/mem_controller.sv
// Round-robin arbiter from NUM_LANES LSU lanes onto one valid/ready data-memory port,
// one transaction in flight, with per-lane ack pulses and held read data.
module mem_controller #(
  parameter int unsigned NUM_LANES  = 4,
  parameter int unsigned ADDR_WIDTH = 7,
  parameter int unsigned DATA_WIDTH = 64
) (
  input logic              clk,
  input logic              rst,
  mem_controller_if.slave  bus
);

  localparam int unsigned LANE_W = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_ACK   = 2'd3
  } state_e;

  state_e                          state_q, state_d;
  logic [LANE_W-1:0]               ptr_q, ptr_d;
  logic [NUM_LANES-1:0]            served_q, served_d;
  logic [LANE_W-1:0]               lane_q, lane_d;
  logic                            is_read_q, is_read_d;
  logic [ADDR_WIDTH-1:0]           addr_q, addr_d;
  logic [DATA_WIDTH-1:0]           wdata_q, wdata_d;
  logic                            rd_valid_q, rd_valid_d;
  logic                            wr_valid_q, wr_valid_d;
  logic [NUM_LANES-1:0]            rack_q, rack_d;
  logic [NUM_LANES-1:0]            wack_q, wack_d;
  logic [NUM_LANES*DATA_WIDTH-1:0] rdata_q, rdata_d;

  logic [NUM_LANES-1:0]            req_c;
  logic [NUM_LANES-1:0]            eligible_c;
  logic                            found_c;
  logic [LANE_W-1:0]               grant_c;
  logic [LANE_W-1:0]               cand_c;
  logic                            done_c;

  assign req_c      = bus.lane_read_valid | bus.lane_write_valid;
  assign eligible_c = req_c & ~served_q;

  // First eligible lane scanning upward from the round-robin pointer
  always_comb begin
    found_c = 1'b0;
    grant_c = '0;
    cand_c  = '0;
    for (int unsigned i = 0; i < NUM_LANES; i++) begin
      cand_c = LANE_W'((32'(ptr_q) + i) % NUM_LANES);
      if (!found_c && eligible_c[cand_c]) begin
        found_c = 1'b1;
        grant_c = cand_c;
      end
    end
  end

  // Only the channel that was issued can complete the transaction
  assign done_c = is_read_q ? bus.mem_read_ready : bus.mem_write_ready;

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    served_d   = served_q & req_c;
    lane_d     = lane_q;
    is_read_d  = is_read_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rd_valid_d = rd_valid_q;
    wr_valid_d = wr_valid_q;
    rack_d     = '0;
    wack_d     = '0;
    rdata_d    = rdata_q;

    case (state_q)
      S_IDLE: begin
        if (found_c) begin
          lane_d     = grant_c;
          is_read_d  = bus.lane_read_valid[grant_c];
          addr_d     = bus.lane_read_valid[grant_c]
                     ? bus.lane_read_addr[grant_c*ADDR_WIDTH +: ADDR_WIDTH]
                     : bus.lane_write_addr[grant_c*ADDR_WIDTH +: ADDR_WIDTH];
          wdata_d    = bus.lane_write_data[grant_c*DATA_WIDTH +: DATA_WIDTH];
          rd_valid_d = bus.lane_read_valid[grant_c];
          wr_valid_d = ~bus.lane_read_valid[grant_c];
          state_d    = S_ISSUE;
        end
      end
      S_ISSUE: begin
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (done_c) begin
          rd_valid_d = 1'b0;
          wr_valid_d = 1'b0;
          if (is_read_q) begin
            rdata_d[lane_q*DATA_WIDTH +: DATA_WIDTH] = bus.mem_read_data;
          end
          rack_d[lane_q] = is_read_q;
          wack_d[lane_q] = ~is_read_q;
          state_d        = S_ACK;
        end
      end
      S_ACK: begin
        served_d[lane_q] = 1'b1;
        ptr_d            = (32'(lane_q) == NUM_LANES - 1) ? '0 : lane_q + LANE_W'(1);
        state_d          = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      ptr_q      <= '0;
      served_q   <= '0;
      lane_q     <= '0;
      is_read_q  <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rd_valid_q <= 1'b0;
      wr_valid_q <= 1'b0;
      rack_q     <= '0;
      wack_q     <= '0;
      rdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      served_q   <= served_d;
      lane_q     <= lane_d;
      is_read_q  <= is_read_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rd_valid_q <= rd_valid_d;
      wr_valid_q <= wr_valid_d;
      rack_q     <= rack_d;
      wack_q     <= wack_d;
      rdata_q    <= rdata_d;
    end
  end

  assign bus.mem_read_valid  = rd_valid_q;
  assign bus.mem_read_addr   = addr_q;
  assign bus.mem_write_valid = wr_valid_q;
  assign bus.mem_write_addr  = addr_q;
  assign bus.mem_write_data  = wdata_q;
  assign bus.lane_read_ack   = rack_q;
  assign bus.lane_write_ack  = wack_q;
  assign bus.lane_read_data  = rdata_q;

endmodule

// File: tb/tb_mem_controller.sv
// Scoreboard bench for mem_controller: a behavioural memory, a request monitor and an ack
// monitor compare against expectations queued by each scenario task.
module tb_mem_controller;
  localparam int unsigned NL = 4;
  localparam int unsigned AW = 7;
  localparam int unsigned DW = 64;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  mem_controller_if #(.NUM_LANES(NL), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  mem_controller #(.NUM_LANES(NL), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct { bit is_read; int lane; logic [DW-1:0] data; } ack_t;
  typedef struct { bit is_write; logic [AW-1:0] addr; logic [DW-1:0] data; } req_t;

  ack_t ack_q[$];
  req_t req_q[$];
  logic [DW-1:0] mem_arr [128];
  int mem_lat = 1;
  int mem_cnt = 0;
  int errors = 0;
  int checks = 0;

  // Behavioural memory: ready after mem_lat cycles of valid, released when valid drops
  initial begin
    bus.mem_read_ready  = 1'b0;
    bus.mem_write_ready = 1'b0;
    bus.mem_read_data   = '0;
    forever begin
      @(negedge clk);
      if (bus.mem_read_valid || bus.mem_write_valid) begin
        mem_cnt++;
        if (mem_cnt >= mem_lat) begin
          if (bus.mem_read_valid) begin
            bus.mem_read_ready = 1'b1;
            bus.mem_read_data  = mem_arr[bus.mem_read_addr];
          end else begin
            bus.mem_write_ready = 1'b1;
            mem_arr[bus.mem_write_addr] = bus.mem_write_data;
          end
        end
      end else begin
        mem_cnt = 0;
        bus.mem_read_ready  = 1'b0;
        bus.mem_write_ready = 1'b0;
      end
    end
  end

  // Memory-side monitor: each new request must match the head of req_q
  logic prev_r = 1'b0, prev_w = 1'b0;
  req_t rq;
  always @(negedge clk) begin
    if (bus.mem_read_valid || bus.mem_write_valid) begin
      checks++;
      if (bus.mem_read_valid && bus.mem_write_valid) begin
        errors++;
        $display("FAIL both_valid: read and write valid together at %0t, required one-hot", $time);
      end
    end
    if ((bus.mem_read_valid && !prev_r) || (bus.mem_write_valid && !prev_w)) begin
      checks++;
      if (req_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_mem_req: wr=%0b addr=%h at %0t, required none",
                 bus.mem_write_valid, bus.mem_write_valid ? bus.mem_write_addr : bus.mem_read_addr, $time);
      end else begin
        rq = req_q.pop_front();
        if (bus.mem_write_valid !== rq.is_write ||
            (rq.is_write && (bus.mem_write_addr !== rq.addr || bus.mem_write_data !== rq.data)) ||
            (!rq.is_write && bus.mem_read_addr !== rq.addr)) begin
          errors++;
          $display("FAIL mem_req: got wr=%0b raddr=%h waddr=%h wdata=%h, required wr=%0b addr=%h data=%h",
                   bus.mem_write_valid, bus.mem_read_addr, bus.mem_write_addr, bus.mem_write_data,
                   rq.is_write, rq.addr, rq.data);
        end
      end
    end
    prev_r = bus.mem_read_valid;
    prev_w = bus.mem_write_valid;
  end

  // Lane-side monitor: every ack cycle pops one expectation
  ack_t aq;
  always @(negedge clk) begin
    for (int k = 0; k < NL; k++) begin
      if (bus.lane_read_ack[k] || bus.lane_write_ack[k]) begin
        checks++;
        if (ack_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_ack: lane %0d rd=%0b at %0t, required none", k, bus.lane_read_ack[k], $time);
        end else begin
          aq = ack_q.pop_front();
          if (aq.lane != k || aq.is_read !== bus.lane_read_ack[k] ||
              (aq.is_read && bus.lane_read_data[k*DW +: DW] !== aq.data)) begin
            errors++;
            $display("FAIL ack: got lane %0d rd=%0b data=%h, required lane %0d rd=%0b data=%h",
                     k, bus.lane_read_ack[k], bus.lane_read_data[k*DW +: DW], aq.lane, aq.is_read, aq.data);
          end
        end
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_read(input int k, input bit v, input logic [AW-1:0] a);
    bus.lane_read_valid[k]        = v;
    bus.lane_read_addr[k*AW +: AW] = a;
  endtask

  task automatic set_write(input int k, input bit v, input logic [AW-1:0] a, input logic [DW-1:0] d);
    bus.lane_write_valid[k]         = v;
    bus.lane_write_addr[k*AW +: AW]  = a;
    bus.lane_write_data[k*DW +: DW]  = d;
  endtask

  task automatic push_read(input int k, input logic [AW-1:0] a);
    req_q.push_back('{is_write: 1'b0, addr: a, data: '0});
    ack_q.push_back('{is_read: 1'b1, lane: k, data: mem_arr[a]});
  endtask

  task automatic push_write(input int k, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_q.push_back('{is_write: 1'b1, addr: a, data: d});
    ack_q.push_back('{is_read: 1'b0, lane: k, data: '0});
  endtask

  task automatic drop_all();
    bus.lane_read_valid  = '0;
    bus.lane_write_valid = '0;
  endtask

  task automatic wait_drain(input string name, input int budget);
    int n = 0;
    while (ack_q.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    cyc(1);
    checks++;
    if (ack_q.size() != 0 || req_q.size() != 0) begin
      errors++;
      $display("FAIL %s_drain: %0d acks and %0d requests outstanding, required 0",
               name, ack_q.size(), req_q.size());
      ack_q.delete();
      req_q.delete();
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    for (int k = 0; k < NL; k++) set_read(k, 1'b1, AW'(8'h10 + k));
    cyc(3);
    checks++;
    if (bus.lane_read_ack !== '0 || bus.lane_write_ack !== '0) begin
      errors++;
      $display("FAIL reset_acks: got r=%b w=%b, required 0", bus.lane_read_ack, bus.lane_write_ack);
    end
    checks++;
    if (bus.mem_read_valid !== 1'b0 || bus.mem_write_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_mem_valid: got r=%b w=%b, required 0", bus.mem_read_valid, bus.mem_write_valid);
    end
    checks++;
    if (bus.lane_read_data !== '0) begin
      errors++;
      $display("FAIL reset_rdata: got %h, required 0", bus.lane_read_data);
    end
    for (int k = 0; k < NL; k++) push_read(k, AW'(8'h10 + k));
    rst = 1'b1;
    cyc(1);
    checks++;
    if (bus.mem_read_valid !== 1'b1 || bus.mem_read_addr !== 7'h10) begin
      errors++;
      $display("FAIL reset_first_grant: got valid=%b addr=%h, required valid=1 addr=10",
               bus.mem_read_valid, bus.mem_read_addr);
    end
    wait_drain("reset", 60);
    drop_all();
    cyc(2);
  endtask

  task automatic test_round_robin();
    for (int k = 0; k < NL; k++) push_write(k, AW'(k), DW'(k + 100));
    for (int k = 0; k < NL; k++) set_write(k, 1'b1, AW'(k), DW'(k + 100));
    wait_drain("round_robin", 60);
    for (int k = 0; k < NL; k++) begin
      checks++;
      if (mem_arr[k] !== DW'(k + 100)) begin
        errors++;
        $display("FAIL rr_mem_content: mem[%0d]=%0d, required %0d", k, mem_arr[k], k + 100);
      end
    end
    drop_all();
    cyc(2);
  endtask

  task automatic test_single_read();
    int n = 0;
    mem_arr[7'h15] = 64'hDEAD_BEEF;
    mem_lat = 3;
    push_read(2, 7'h15);
    set_read(2, 1'b1, 7'h15);
    while (!bus.lane_read_ack[2] && n < 30) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (bus.lane_read_ack[2] !== 1'b1) begin
      errors++;
      $display("FAIL single_read_ack: lane 2 ack not seen within 30 cycles, required ack");
    end
    set_read(2, 1'b0, 7'h15);
    cyc(1);
    checks++;
    if (bus.lane_read_ack !== '0 || bus.lane_read_data[2*DW +: DW] !== 64'hDEAD_BEEF) begin
      errors++;
      $display("FAIL single_read_hold: got ack=%b data=%h, required ack=0 data=deadbeef",
               bus.lane_read_ack, bus.lane_read_data[2*DW +: DW]);
    end
    wait_drain("single_read", 10);
    mem_lat = 1;
    cyc(2);
  endtask

  task automatic test_sticky_valid();
    int n = 0;
    int extra = 0;
    push_write(1, 7'h33, 64'h1111_2222_3333_4444);
    set_write(1, 1'b1, 7'h33, 64'h1111_2222_3333_4444);
    while (!bus.lane_write_ack[1] && n < 30) begin
      @(negedge clk);
      n++;
    end
    repeat (10) begin
      @(negedge clk);
      if (bus.mem_write_valid || bus.lane_write_ack[1]) extra++;
    end
    checks++;
    if (extra != 0) begin
      errors++;
      $display("FAIL sticky_no_reserve: %0d busy cycles while valid held, required 0", extra);
    end
    set_write(1, 1'b0, 7'h33, 64'h1111_2222_3333_4444);
    cyc(1);
    push_write(1, 7'h34, 64'h5555_6666_7777_8888);
    set_write(1, 1'b1, 7'h34, 64'h5555_6666_7777_8888);
    wait_drain("sticky", 30);
    cyc(8);
    checks++;
    if (mem_arr[7'h34] !== 64'h5555_6666_7777_8888) begin
      errors++;
      $display("FAIL sticky_rewrite: mem[34]=%h, required 5555666677778888", mem_arr[7'h34]);
    end
    drop_all();
    cyc(2);
  endtask

  task automatic test_read_write_same_lane();
    int wr_seen = 0;
    push_read(0, 7'h40);
    set_read(0, 1'b1, 7'h40);
    set_write(0, 1'b1, 7'h41, 64'hFACE_0000_0000_0041);
    wait_drain("rw_read", 30);
    repeat (6) begin
      @(negedge clk);
      if (bus.mem_write_valid) wr_seen++;
    end
    checks++;
    if (wr_seen != 0) begin
      errors++;
      $display("FAIL rw_no_write: %0d write cycles before re-request, required 0", wr_seen);
    end
    drop_all();
    cyc(1);
    push_write(0, 7'h41, 64'hFACE_0000_0000_0041);
    set_write(0, 1'b1, 7'h41, 64'hFACE_0000_0000_0041);
    wait_drain("rw_write", 30);
    drop_all();
    cyc(2);
  endtask

  task automatic test_latency();
    mem_lat = 1;
    push_read(3, 7'h22);
    set_read(3, 1'b1, 7'h22);
    cyc(1);
    checks++;
    if (bus.mem_read_valid !== 1'b1 || bus.lane_read_ack !== '0) begin
      errors++;
      $display("FAIL lat_cycle1: got valid=%b ack=%b, required valid=1 ack=0", bus.mem_read_valid, bus.lane_read_ack);
    end
    cyc(1);
    checks++;
    if (bus.mem_read_valid !== 1'b1) begin
      errors++;
      $display("FAIL lat_cycle2: got valid=%b, required 1", bus.mem_read_valid);
    end
    cyc(1);
    checks++;
    if (bus.lane_read_ack !== 4'b1000 || bus.mem_read_valid !== 1'b0) begin
      errors++;
      $display("FAIL lat_cycle3: got ack=%b valid=%b, required ack=1000 valid=0", bus.lane_read_ack, bus.mem_read_valid);
    end
    wait_drain("latency", 10);
    drop_all();
    cyc(2);
  endtask

  task automatic test_midflight_reset();
    int n = 0;
    int acks = 0;
    mem_lat = 6;
    req_q.push_back('{is_write: 1'b0, addr: 7'h50, data: '0});
    set_read(3, 1'b1, 7'h50);
    while (!bus.mem_read_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    cyc(1);
    #2 rst = 1'b0;
    #1;
    checks++;
    if (bus.mem_read_valid !== 1'b0) begin
      errors++;
      $display("FAIL midreset_valid: got %b, required 0", bus.mem_read_valid);
    end
    repeat (3) begin
      @(negedge clk);
      if (bus.lane_read_ack !== '0) acks++;
    end
    checks++;
    if (acks != 0 || bus.lane_read_data !== '0) begin
      errors++;
      $display("FAIL midreset_no_ack: got %0d ack cycles data=%h, required 0 and 0", acks, bus.lane_read_data);
    end
    mem_lat = 2;
    push_read(3, 7'h50);
    rst = 1'b1;
    wait_drain("midreset", 30);
    drop_all();
    cyc(2);
  endtask

  initial begin
    bus.lane_read_valid  = '0;
    bus.lane_read_addr   = '0;
    bus.lane_write_valid = '0;
    bus.lane_write_addr  = '0;
    bus.lane_write_data  = '0;
    for (int a = 0; a < 128; a++) mem_arr[a] = {32'hC0DE_0000, 32'(a) * 32'h0101_0101};
    test_reset();
    test_round_robin();
    test_single_read();
    test_sticky_valid();
    test_read_write_same_lane();
    test_latency();
    test_midflight_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
